relogio_johnson_param: RTL and testbench
========================================

Name: relogio_johnson_param

Overview:
Parametrised HH:MM:SS real-time clock core. It counts seconds from a programmable clock prescaler and supports 24 h or 12 h (AM/PM) mode. Time loads are validated, and an HH:MM alarm comparator is included. Each digit is driven out as one-hot or true Johnson code for the display/decoder stage.

Parameters:
CLK_DIV, 1, clk cycles per second tick (>=1); 1 means every cycle is a tick.
MODE_12H, 0, 0 = 24 h (00..23), 1 = 12 h (12,01..11 with pm flag).
ENC, 0, digit output code: 0 = one-hot in 10 bits, 1 = 5-bit Johnson code in bits [4:0] with [9:5]=0.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
LD_time  in  1  load H_in*/M_in*/pm_in; seconds cleared to 00.
H_in1  in  2  hour tens (BCD).
H_in0  in  4  hour units (BCD).
M_in1  in  4  minute tens (BCD).
M_in0  in  4  minute units (BCD).
pm_in  in  1  PM flag for load (MODE_12H=1 only; ignored otherwise).
AL_set  in  1  load alarm HH:MM (and pm) from the same H_in*/M_in*/pm_in bus.
AL_en  in  1  alarm enable.
sec_tick  out  1  one-cycle pulse on each second increment.
pm  out  1  PM flag (always 0 when MODE_12H=0).
alarm  out  1  one-cycle pulse on alarm match.
load_err  out  1  one-cycle pulse when LD_time/AL_set data is rejected.
H_out1, H_out0, M_out1, M_out0, S_out1, S_out0  out  10 each  encoded digits.

Behaviour:
- Reset (reset=0, async) forces the following state.
  - 24 h mode: time 00:00:00.
  - 12 h mode: time 12:00:00 with pm=0.
  - Prescaler = 0; alarm register = reset time with alarm disabled-match.
  - sec_tick, alarm, load_err = 0.
- Prescaler counts 0..CLK_DIV-1. tick is asserted internally in the cycle where count == CLK_DIV-1. sec_tick is registered, so it is high in the cycle after the increment edge, aligned with the new time.
- Priority per edge: LD_time > tick. AL_set is independent of both.
- Load validation: all digits BCD, M_in1 <= 5.
  - 24 h mode: hour 00..23.
  - 12 h mode: hour 01..12.
- Valid LD_time: on the next edge the time is set, seconds = 00, the prescaler is cleared and a tick in that cycle is discarded.
- Invalid LD_time: time is unchanged and load_err pulses one cycle. AL_set uses the same validation and error pulse.
- Seconds: 0..59. At 59 on tick, wrap to 00 and carry to minutes.
- Minutes: 0..59. Carry to hours at 59 with a seconds carry.
- Hours, 24 h mode: 23:59:59 -> 00:00:00. Units wrap 9 -> 0 with a tens increment; 23 wraps to 00.
- Hours, 12 h mode:
  - 11:59:59 -> 12:00:00 with pm toggled.
  - 12:59:59 -> 01:00:00 with pm unchanged.
  - 09 -> 10 and 10 -> 11 carry normally.
- Alarm: asserted one cycle (registered) after the tick edge that makes time == alarm HH:MM:00 (and pm equal in 12 h mode), gated by AL_en.
  - A load that sets a matching time does not fire the alarm.
  - AL_set coinciding with a matching tick compares against the old alarm value.
- Encoding is combinational from the digit registers, zero latency.
  - ENC=0: one-hot, bit[d]=1.
  - ENC=1: Johnson code, 5-bit, d=0 -> 00000, d=1..5 -> fill ones from LSB, d=6..9 -> shift zeros in from LSB. Values are 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
- Reset asserted mid-count aborts immediately. There are no pending pulses after release.
- Digit registers never hold illegal values. This is a required assertion.

Decomposition:
- Package relogio_pkg holds:
  - BCD digit type.
  - Limits SEC_MAX=59, MIN_MAX=59, H24_MAX=23, H12_MIN=1, H12_MAX=12.
  - The Johnson lookup constant.
  - Function bcd_valid_time(h1, h0, m1, m0, mode).
- One sub-module, digit_encoder: 4-bit digit + ENC -> 10-bit code, instantiated 6 times.

Test Plan:
- CLK_DIV=1, MODE_12H=0: load 23:59, run 60 cycles -> time 00:00:00 after tick 60, sec_tick high each cycle, H_out1=10'b0000000001.
- CLK_DIV=4: run after reset -> sec_tick every 4th cycle; load on the cycle the prescaler equals 3 -> seconds stay 00 and the next tick arrives 4 cycles later.
- Load 25:00 (24 h mode) and 00:30 (12 h mode) -> load_err one cycle, time unchanged. Load 12:7A -> rejected.
- MODE_12H=1: load 11:59 pm=0, run 60 ticks -> 12:00:00 with pm=1. Load 12:59 pm=1, run 60 ticks -> 01:00:00 with pm=1.
- Alarm 00:01, AL_en=1, load 00:00 -> alarm single pulse exactly when time becomes 00:01:00. With AL_en=0 -> no pulse.
- ENC=1, seconds 0..9 -> S_out0 steps through the Johnson sequence above. Assert reset mid-run -> all outputs at reset values within the same cycle, asynchronously.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types, limits and helpers for the HH:MM:SS clock core.
// Latency: n/a (package only).
// Backpressure: n/a.
package relogio_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int H24_MAX = 23;
  localparam int H12_MIN = 1;
  localparam int H12_MAX = 12;

  // Five-bit Johnson codes for digits 0..9, digit d at bits [d*5 +: 5].
  localparam logic [49:0] JOHNSON_LUT = {
    5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
    5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000
  };

  // True when h1h0:m1m0 is a legal time of day for the selected hour mode
  // (mode=1 -> 12 h, hours 01..12; mode=0 -> 24 h, hours 00..23).
  function automatic logic bcd_valid_time(input logic [1:0] h1, input bcd_t h0,
                                          input bcd_t m1, input bcd_t m0,
                                          input logic mode);
    int   hr;
    logic ok;
    hr = int'(h1) * 10 + int'(h0);
    ok = (h0 <= 4'd9) && (m1 <= 4'(MIN_MAX / 10)) && (m0 <= 4'd9);
    if (mode) ok = ok && (hr >= H12_MIN) && (hr <= H12_MAX);
    else      ok = ok && (hr <= H24_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/digit_encoder.sv
// Converts one BCD digit to a 10-bit display code (one-hot or 5-bit Johnson).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: digit (BCD 0..9, anything else yields all zeros), code (10-bit output).
module digit_encoder
  import relogio_pkg::*;
#(
  parameter int ENC = 0
) (
  input  bcd_t       digit,
  output logic [9:0] code
);

  always_comb begin
    code = '0;
    if (digit <= 4'd9) begin
      if (ENC == 0) code = 10'd1 << digit;
      else          code[4:0] = JOHNSON_LUT[int'(digit) * 5 +: 5];
    end
  end

endmodule

// File: rtl/relogio_johnson_param.sv
// HH:MM:SS real-time clock with prescaler, 12/24 h modes, validated loads and HH:MM alarm.
// Latency: time/pulses registered one edge after tick/load; digit encoding is combinational.
// Backpressure: none; LD_time wins over a coincident tick, AL_set is independent.
// Ports: clk, reset (async active-low); LD_time/AL_set load H_in1,H_in0,M_in1,M_in0,pm_in;
//        AL_en gates alarm; sec_tick/alarm/load_err are one-cycle pulses; pm flag;
//        H_out1..S_out0 are encoded digits.
module relogio_johnson_param
  import relogio_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int MODE_12H = 0,
  parameter int ENC      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LD_time,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       pm_in,
  input  logic       AL_set,
  input  logic       AL_en,
  output logic       sec_tick,
  output logic       pm,
  output logic       alarm,
  output logic       load_err,
  output logic [9:0] H_out1,
  output logic [9:0] H_out0,
  output logic [9:0] M_out1,
  output logic [9:0] M_out0,
  output logic [9:0] S_out1,
  output logic [9:0] S_out0
);

  localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic          IS12    = (MODE_12H != 0);
  // Reset time is 00:00 in 24 h mode and 12:00 AM in 12 h mode.
  localparam logic [1:0]    RST_H1  = IS12 ? 2'(H12_MAX / 10) : 2'd0;
  localparam bcd_t          RST_H0  = IS12 ? 4'(H12_MAX % 10) : 4'd0;

  logic [PW-1:0] ps;
  logic [1:0]    h1, ah1, nh1;
  bcd_t          h0, m1, m0, s1, s0;
  bcd_t          ah0, am1, am0;
  bcd_t          nh0, nm1, nm0, ns1, ns0;
  logic          pm_q, apm, npm;
  logic          tick, ld_ok, al_ok, alarm_match, digits_legal;
  int            hour_now;

  // Next time assuming a tick is taken this cycle.
  always_comb begin
    tick     = (ps == PS_LAST);
    ld_ok    = bcd_valid_time(H_in1, H_in0, M_in1, M_in0, IS12);
    al_ok    = ld_ok;
    hour_now = int'(h1) * 10 + int'(h0);
    nh1 = h1; nh0 = h0; nm1 = m1; nm0 = m0; ns1 = s1; ns0 = s0; npm = pm_q;
    if (s0 != 4'd9) ns0 = s0 + 4'd1;
    else begin
      ns0 = 4'd0;
      if (s1 != 4'(SEC_MAX / 10)) ns1 = s1 + 4'd1;
      else begin
        ns1 = 4'd0;
        if (m0 != 4'd9) nm0 = m0 + 4'd1;
        else begin
          nm0 = 4'd0;
          if (m1 != 4'(MIN_MAX / 10)) nm1 = m1 + 4'd1;
          else begin
            nm1 = 4'd0;
            if (IS12 && hour_now == H12_MAX - 1) begin
              // 11 -> 12 is where AM/PM flips.
              nh1 = 2'(H12_MAX / 10); nh0 = 4'(H12_MAX % 10); npm = ~pm_q;
            end else if (IS12 && hour_now == H12_MAX) begin
              nh1 = 2'(H12_MIN / 10); nh0 = 4'(H12_MIN % 10);
            end else if (!IS12 && hour_now == H24_MAX) begin
              nh1 = 2'd0; nh0 = 4'd0;
            end else if (h0 == 4'd9) begin
              nh1 = h1 + 2'd1; nh0 = 4'd0;
            end else begin
              nh0 = h0 + 4'd1;
            end
          end
        end
      end
    end
    alarm_match = (nh1 == ah1) && (nh0 == ah0) && (nm1 == am1) && (nm0 == am0) &&
                  (ns1 == 4'd0) && (ns0 == 4'd0) && (npm == apm);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps       <= '0;
      h1       <= RST_H1; h0 <= RST_H0;
      m1       <= '0; m0 <= '0; s1 <= '0; s0 <= '0;
      pm_q     <= 1'b0;
      ah1      <= RST_H1; ah0 <= RST_H0;
      am1      <= '0; am0 <= '0;
      apm      <= 1'b0;
      sec_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= (LD_time && !ld_ok) || (AL_set && !al_ok);
      if (LD_time) begin
        // A load owns the cycle: any coincident tick is dropped, even when
        // the load itself is rejected.
        if (ld_ok) begin
          ps   <= '0;
          h1   <= H_in1; h0 <= H_in0; m1 <= M_in1; m0 <= M_in0;
          s1   <= '0;    s0 <= '0;
          pm_q <= pm_in & IS12;
        end else begin
          ps <= tick ? '0 : ps + PW'(1);
        end
      end else begin
        ps <= tick ? '0 : ps + PW'(1);
        if (tick) begin
          h1 <= nh1; h0 <= nh0; m1 <= nm1; m0 <= nm0; s1 <= ns1; s0 <= ns0;
          pm_q     <= npm;
          sec_tick <= 1'b1;
          // Compared against the alarm value held before any same-edge AL_set.
          alarm    <= AL_en && alarm_match;
        end
      end
      if (AL_set && al_ok) begin
        ah1 <= H_in1; ah0 <= H_in0; am1 <= M_in1; am0 <= M_in0;
        apm <= pm_in & IS12;
      end
    end
  end

  assign pm = pm_q;

  always_comb begin
    digits_legal = (s0 <= 4'd9) && (s1 <= 4'(SEC_MAX / 10)) &&
                   (m0 <= 4'd9) && (m1 <= 4'(MIN_MAX / 10)) && (h0 <= 4'd9) &&
                   (IS12 || !pm_q);
    if (IS12) digits_legal = digits_legal && hour_now >= H12_MIN && hour_now <= H12_MAX;
    else      digits_legal = digits_legal && hour_now <= H24_MAX;
  end

  assert property (@(posedge clk) disable iff (!reset) digits_legal);

  digit_encoder #(.ENC(ENC)) u_enc_h1 (.digit({2'b00, h1}), .code(H_out1));
  digit_encoder #(.ENC(ENC)) u_enc_h0 (.digit(h0),          .code(H_out0));
  digit_encoder #(.ENC(ENC)) u_enc_m1 (.digit(m1),          .code(M_out1));
  digit_encoder #(.ENC(ENC)) u_enc_m0 (.digit(m0),          .code(M_out0));
  digit_encoder #(.ENC(ENC)) u_enc_s1 (.digit(s1),          .code(S_out1));
  digit_encoder #(.ENC(ENC)) u_enc_s0 (.digit(s0),          .code(S_out0));

endmodule

// File: tb/tb_relogio_johnson_param.sv
// Bench for relogio_johnson_param: three configurations share one input bus and are
// checked every cycle against a seconds-of-day model, plus literal spot checks.
// Configs: dut0 = 1 clk/s 24 h one-hot, dut1 = 4 clk/s 24 h Johnson, dut2 = 1 clk/s 12 h one-hot.
module tb_relogio_johnson_param;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic LD_time = 1'b0, AL_set = 1'b0, AL_en = 1'b0, pm_in = 1'b0;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;

  logic [N-1:0] sec_tick_o, pm_o, alarm_o, err_o;
  logic [N-1:0][9:0] h1o, h0o, m1o, m0o, s1o, s0o;

  int tests = 0;
  int fails = 0;

  // Model state: time as seconds of day (0 = midnight / 12 AM), prescaler count,
  // alarm as minutes of day, and the pulses expected after the latest edge.
  int t[N], p[N], alm[N];
  bit e_tick[N], e_al[N], e_err[N];

  always #5 clk = ~clk;

  relogio_johnson_param #(.CLK_DIV(1), .MODE_12H(0), .ENC(0)) u0 (
    .clk(clk), .reset(reset), .LD_time(LD_time), .H_in1(H_in1), .H_in0(H_in0),
    .M_in1(M_in1), .M_in0(M_in0), .pm_in(pm_in), .AL_set(AL_set), .AL_en(AL_en),
    .sec_tick(sec_tick_o[0]), .pm(pm_o[0]), .alarm(alarm_o[0]), .load_err(err_o[0]),
    .H_out1(h1o[0]), .H_out0(h0o[0]), .M_out1(m1o[0]), .M_out0(m0o[0]),
    .S_out1(s1o[0]), .S_out0(s0o[0]));

  relogio_johnson_param #(.CLK_DIV(4), .MODE_12H(0), .ENC(1)) u1 (
    .clk(clk), .reset(reset), .LD_time(LD_time), .H_in1(H_in1), .H_in0(H_in0),
    .M_in1(M_in1), .M_in0(M_in0), .pm_in(pm_in), .AL_set(AL_set), .AL_en(AL_en),
    .sec_tick(sec_tick_o[1]), .pm(pm_o[1]), .alarm(alarm_o[1]), .load_err(err_o[1]),
    .H_out1(h1o[1]), .H_out0(h0o[1]), .M_out1(m1o[1]), .M_out0(m0o[1]),
    .S_out1(s1o[1]), .S_out0(s0o[1]));

  relogio_johnson_param #(.CLK_DIV(1), .MODE_12H(1), .ENC(0)) u2 (
    .clk(clk), .reset(reset), .LD_time(LD_time), .H_in1(H_in1), .H_in0(H_in0),
    .M_in1(M_in1), .M_in0(M_in0), .pm_in(pm_in), .AL_set(AL_set), .AL_en(AL_en),
    .sec_tick(sec_tick_o[2]), .pm(pm_o[2]), .alarm(alarm_o[2]), .load_err(err_o[2]),
    .H_out1(h1o[2]), .H_out0(h0o[2]), .M_out1(m1o[2]), .M_out0(m0o[2]),
    .S_out1(s1o[2]), .S_out0(s0o[2]));

  function automatic int cdiv(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic bit is12(input int i);
    return (i == 2);
  endfunction

  function automatic int encp(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic bit valid_in(input int hh1, input int hh0, input int mm1, input int mm0,
                                  input bit m12);
    int hr;
    hr = hh1 * 10 + hh0;
    if (hh0 > 9 || mm0 > 9 || mm1 > 5) return 1'b0;
    if (m12) return (hr >= 1 && hr <= 12);
    return (hr <= 23);
  endfunction

  function automatic int to_h24(input int hr, input bit pmv, input bit m12);
    if (!m12) return hr;
    return (hr % 12) + (pmv ? 12 : 0);
  endfunction

  // One-hot: single bit d. Johnson: d ones from the LSB up to 5, then zeros shift in.
  function automatic logic [9:0] enc(input int d, input int e);
    if (e == 0) return 10'd1 << d;
    if (d <= 5) return 10'((1 << d) - 1);
    return 10'((31 << (d - 5)) & 31);
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Reference model, advanced on every active edge and on async reset.
  initial begin
    for (int i = 0; i < N; i++) begin
      t[i] = 0; p[i] = 0; alm[i] = 0; e_tick[i] = 0; e_al[i] = 0; e_err[i] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      for (int i = 0; i < N; i++) begin
        if (!reset) begin
          t[i] = 0; p[i] = 0; alm[i] = 0; e_tick[i] = 0; e_al[i] = 0; e_err[i] = 0;
        end else begin
          bit tk, ok;
          int hr, mn;
          tk = (p[i] == cdiv(i) - 1);
          ok = valid_in(int'(H_in1), int'(H_in0), int'(M_in1), int'(M_in0), is12(i));
          hr = to_h24(int'(H_in1) * 10 + int'(H_in0), pm_in, is12(i));
          mn = int'(M_in1) * 10 + int'(M_in0);
          e_err[i]  = (LD_time && !ok) || (AL_set && !ok);
          e_tick[i] = 0;
          e_al[i]   = 0;
          if (LD_time && ok) begin
            t[i] = hr * 3600 + mn * 60;
            p[i] = 0;
          end else begin
            p[i] = tk ? 0 : p[i] + 1;
            if (!LD_time && tk) begin
              t[i] = (t[i] + 1) % 86400;
              e_tick[i] = 1;
              e_al[i] = AL_en && (t[i] == alm[i] * 60);
            end
          end
          if (AL_set && ok) alm[i] = hr * 60 + mn;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        for (int i = 0; i < N; i++) begin
          int h24, hd, mm, ss;
          bit epm;
          h24 = t[i] / 3600;
          mm  = (t[i] / 60) % 60;
          ss  = t[i] % 60;
          if (is12(i)) begin
            epm = (h24 >= 12);
            hd  = h24 % 12;
            if (hd == 0) hd = 12;
          end else begin
            epm = 1'b0;
            hd  = h24;
          end
          check("H_out1", i, 32'(h1o[i]), 32'(enc(hd / 10, encp(i))));
          check("H_out0", i, 32'(h0o[i]), 32'(enc(hd % 10, encp(i))));
          check("M_out1", i, 32'(m1o[i]), 32'(enc(mm / 10, encp(i))));
          check("M_out0", i, 32'(m0o[i]), 32'(enc(mm % 10, encp(i))));
          check("S_out1", i, 32'(s1o[i]), 32'(enc(ss / 10, encp(i))));
          check("S_out0", i, 32'(s0o[i]), 32'(enc(ss % 10, encp(i))));
          check("pm", i, 32'(pm_o[i]), 32'(epm));
          check("sec_tick", i, 32'(sec_tick_o[i]), 32'(e_tick[i]));
          check("alarm", i, 32'(alarm_o[i]), 32'(e_al[i]));
          check("load_err", i, 32'(err_o[i]), 32'(e_err[i]));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_bus(input int hh1, input int hh0, input int mm1, input int mm0,
                         input bit pmv);
    H_in1 = 2'(hh1); H_in0 = 4'(hh0); M_in1 = 4'(mm1); M_in0 = 4'(mm0); pm_in = pmv;
  endtask

  task automatic do_load(input int hh1, input int hh0, input int mm1, input int mm0,
                         input bit pmv);
    set_bus(hh1, hh0, mm1, mm0, pmv);
    LD_time = 1'b1;
    step();
    LD_time = 1'b0;
  endtask

  task automatic do_alset(input int hh1, input int hh0, input int mm1, input int mm0,
                          input bit pmv);
    set_bus(hh1, hh0, mm1, mm0, pmv);
    AL_set = 1'b1;
    step();
    AL_set = 1'b0;
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int hh, mm;
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 6))
          0: hh = 0;  1: hh = 1;  2: hh = 11; 3: hh = 12;
          4: hh = 23; 5: hh = 9;  default: hh = 10;
        endcase
        case ($urandom_range(0, 3))
          0: mm = 0; 1: mm = 59; 2: mm = 1; default: mm = 58;
        endcase
        set_bus(hh / 10, hh % 10, mm / 10, mm % 10, 1'($urandom_range(0, 1)));
      end else begin
        set_bus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
      end
      LD_time = ($urandom_range(0, 99) < 2);
      AL_set  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 5) AL_en = ~AL_en;
      step();
    end
    LD_time = 1'b0;
    AL_set  = 1'b0;
  endtask

  initial begin
    logic [4:0] jt[10];
    int  cnt, at;
    bit  found;
    jt = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
           5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

    // Held in reset: reset-state literals.
    repeat (3) step();
    check("rst S_out0", 0, 32'(s0o[0]), 32'h1);
    check("rst H_out1", 0, 32'(h1o[0]), 32'h1);
    check("rst S_out0 johnson", 1, 32'(s0o[1]), 32'h0);
    check("rst H_out1 12h", 2, 32'(h1o[2]), 32'h2);
    check("rst H_out0 12h", 2, 32'(h0o[2]), 32'h4);
    check("rst pm", 2, 32'(pm_o), 32'h0);
    check("rst sec_tick", 0, 32'(sec_tick_o), 32'h0);
    reset = 1'b1;
    repeat (10) step();

    // 23:59 -> 00:00:00 after 60 ticks on the 1-clk/s 24 h core.
    do_load(2, 3, 5, 9, 1'b0);
    repeat (60) step();
    check("2359 wrap H_out1", 0, 32'(h1o[0]), 32'h1);
    check("2359 wrap H_out0", 0, 32'(h0o[0]), 32'h1);
    check("2359 wrap M_out1", 0, 32'(m1o[0]), 32'h1);
    check("2359 wrap S_out0", 0, 32'(s0o[0]), 32'h1);
    check("2359 wrap sec_tick", 0, 32'(sec_tick_o[0]), 32'h1);

    // Load on the cycle the 4-clk/s prescaler sits at 3: tick dropped, next in 4.
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      if (p[1] == 3) found = 1'b1;
      else step();
    end
    check("prescaler reached 3", 1, 32'(found), 32'h1);
    do_load(1, 0, 2, 0, 1'b0);
    check("ld@3 S_out0", 1, 32'(s0o[1]), 32'h0);
    check("ld@3 sec_tick", 1, 32'(sec_tick_o[1]), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("ld@3 tick spacing", 1, 32'(sec_tick_o[1]), (c == 4) ? 32'h1 : 32'h0);
    end

    // Rejected loads.
    do_load(2, 5, 0, 0, 1'b0);
    check("25:00 load_err", 0, 32'(err_o), 32'h7);
    do_load(0, 0, 3, 0, 1'b0);
    check("00:30 load_err", 0, 32'(err_o), 32'h4);
    do_load(1, 2, 7, 10, 1'b0);
    check("12:7A load_err", 0, 32'(err_o), 32'h7);
    step();
    check("load_err one cycle", 0, 32'(err_o), 32'h0);

    // 12 h rollovers.
    do_load(1, 1, 5, 9, 1'b0);
    repeat (60) step();
    check("11:59am->12 pm", 2, 32'(pm_o[2]), 32'h1);
    check("11:59am->12 H_out1", 2, 32'(h1o[2]), 32'h2);
    check("11:59am->12 H_out0", 2, 32'(h0o[2]), 32'h4);
    do_load(1, 2, 5, 9, 1'b1);
    repeat (60) step();
    check("12:59pm->1 pm", 2, 32'(pm_o[2]), 32'h1);
    check("12:59pm->1 H_out1", 2, 32'(h1o[2]), 32'h1);
    check("12:59pm->1 H_out0", 2, 32'(h0o[2]), 32'h2);

    // Alarm at 00:01 with enable: single pulse exactly 60 ticks after loading 00:00.
    AL_en = 1'b1;
    do_alset(0, 0, 0, 1, 1'b0);
    do_load(0, 0, 0, 0, 1'b0);
    cnt = 0; at = -1;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (alarm_o[0]) begin cnt++; at = c; end
    end
    check("alarm pulse count", 0, 32'(cnt), 32'd1);
    check("alarm pulse cycle", 0, 32'(at), 32'd60);
    AL_en = 1'b0;
    do_load(0, 0, 0, 0, 1'b0);
    cnt = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (alarm_o[0]) cnt++;
    end
    check("alarm disabled count", 0, 32'(cnt), 32'd0);

    // Johnson sequence on seconds units of the 4-clk/s core.
    do_load(1, 0, 2, 0, 1'b0);
    check("johnson 0", 1, 32'(s0o[1]), 32'(jt[0]));
    for (int k = 1; k <= 9; k++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        step();
        if (sec_tick_o[1]) found = 1'b1;
      end
      check("johnson tick seen", 1, 32'(found), 32'h1);
      check("johnson digit", 1, 32'(s0o[1]), 32'(jt[k]));
    end

    random_phase(1500);

    // Asynchronous reset in the middle of a high phase.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async S_out0", 0, 32'(s0o[0]), 32'h1);
    check("async S_out0 johnson", 1, 32'(s0o[1]), 32'h0);
    check("async H_out1 12h", 2, 32'(h1o[2]), 32'h2);
    check("async pulses", 0, 32'({sec_tick_o, alarm_o, err_o, pm_o}), 32'h0);
    repeat (2) step();
    reset = 1'b1;
    AL_en = 1'b1;
    random_phase(1500);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
